cci_mpf_vtp_pt_fim_reader: RTL and testbench

- Memory-side responder for the VTP page-table walker's FIM read port.
- Accepts line-address PT read requests (readEn/readAddr/readRdy) from the walker and issues them as CCI c0 read requests tagged in mdata.
- Collects possibly out-of-order c0 responses in a small reorder buffer (ROB) and returns readDataEn/readData to the walker strictly in request order.
- Sits between the VTP page-table walker and the channel-0 arbiter toward the FIM.

---
 rtl/cci_mpf_vtp_pt_fim_reader.sv | 140 ++++++++++++++
 tb/tb_cci_mpf_vtp_pt_fim_reader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_vtp_pt_fim_reader.sv
// PT walker read port to CCI c0: tags reads by ROB slot in mdata, returns lines in request order.
// Define CCI_MPF_VTP_PT_FIM_READER_STATS_EN to build the completed-read counter on statNumReads.
module cci_mpf_vtp_pt_fim_reader #(
    parameter int         ADDR_WIDTH = 42,
    parameter int         DATA_WIDTH = 512,
    parameter int         MAX_READS  = 4,
    parameter logic [7:0] MDATA_MARK = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  readEn,
    input  logic [ADDR_WIDTH-1:0] readAddr,
    output logic                  readRdy,
    output logic                  readDataEn,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  c0TxValid,
    output logic [ADDR_WIDTH-1:0] c0TxAddr,
    output logic [15:0]           c0TxMdata,
    input  logic                  c0TxAlmFull,
    input  logic                  c0RxValid,
    input  logic [15:0]           c0RxMdata,
    input  logic [DATA_WIDTH-1:0] c0RxData,
    output logic                  errUnexpectedRsp,
    output logic [15:0]           statNumReads
);
    localparam int SLOT_W = $clog2(MAX_READS);
    localparam int CNT_W  = SLOT_W + 1;
    typedef logic [SLOT_W-1:0] slot_t;

    logic [MAX_READS-1:0]  busy_q, busy_d, filled_q, filled_d;
    logic [DATA_WIDTH-1:0] rob_data_q [MAX_READS];
    slot_t                 alloc_q, alloc_d, head_q, head_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [ADDR_WIDTH-1:0] tx_addr_q, tx_addr_d;
    logic [15:0]           tx_mdata_q, tx_mdata_d;
    logic                  rd_en_q, rd_en_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  err_q, err_d;

    logic  accept, release_head, rsp_hit, rsp_ok;
    slot_t rsp_slot;
    logic  unused_mdata;

    assign readRdy      = !c0TxAlmFull && (cnt_q < CNT_W'(MAX_READS));
    assign accept       = readEn && readRdy;
    assign rsp_hit      = c0RxValid && (c0RxMdata[15:8] == MDATA_MARK);
    assign rsp_slot     = c0RxMdata[SLOT_W-1:0];
    assign rsp_ok       = rsp_hit && busy_q[rsp_slot] && !filled_q[rsp_slot];
    assign release_head = filled_q[head_q];
    assign unused_mdata = ^c0RxMdata[7:SLOT_W];

    // Release clears the head before accept marks the alloc slot; the two can only
    // coincide when the ROB is full, and then accept is blocked by readRdy.
    always_comb begin
        busy_d     = busy_q;
        filled_d   = filled_q;
        alloc_d    = alloc_q;
        head_d     = head_q;
        cnt_d      = cnt_q + CNT_W'(accept) - CNT_W'(release_head);
        tx_valid_d = accept;
        tx_addr_d  = tx_addr_q;
        tx_mdata_d = tx_mdata_q;
        rd_en_d    = release_head;
        rd_data_d  = rd_data_q;
        err_d      = err_q | (rsp_hit && !rsp_ok);
        if (release_head) begin
            busy_d[head_q]   = 1'b0;
            filled_d[head_q] = 1'b0;
            head_d           = head_q + slot_t'(1);
            rd_data_d        = rob_data_q[head_q];
        end
        if (accept) begin
            busy_d[alloc_q] = 1'b1;
            alloc_d         = alloc_q + slot_t'(1);
            tx_addr_d       = readAddr;
            tx_mdata_d      = {MDATA_MARK, 8'(alloc_q)};
        end
        if (rsp_ok) filled_d[rsp_slot] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q     <= '0;
            filled_q   <= '0;
            alloc_q    <= '0;
            head_q     <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_addr_q  <= '0;
            tx_mdata_q <= '0;
            rd_en_q    <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            filled_q   <= filled_d;
            alloc_q    <= alloc_d;
            head_q     <= head_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_addr_q  <= tx_addr_d;
            tx_mdata_q <= tx_mdata_d;
            rd_en_q    <= rd_en_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    // Line storage needs no reset: a slot is only read once its filled bit is set.
    always_ff @(posedge clk) begin
        if (rsp_ok) rob_data_q[rsp_slot] <= c0RxData;
    end

    assign c0TxValid        = tx_valid_q;
    assign c0TxAddr         = tx_addr_q;
    assign c0TxMdata        = tx_mdata_q;
    assign readDataEn       = rd_en_q;
    assign readData         = rd_data_q;
    assign errUnexpectedRsp = err_q;

`ifdef CCI_MPF_VTP_PT_FIM_READER_STATS_EN
    logic [15:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (release_head && (stat_q != 16'hFFFF)) stat_d = stat_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stat_q <= '0;
        else          stat_q <= stat_d;
    end

    assign statNumReads = stat_q;
`else
    assign statNumReads = '0;
`endif

endmodule

// File: tb/tb_cci_mpf_vtp_pt_fim_reader.sv
// Directed and randomized checks of the PT FIM reader against an in-order queue model with a random-latency FIM.
module tb_cci_mpf_vtp_pt_fim_reader;
    localparam int AW   = 42;
    localparam int DW   = 512;
    localparam int MAXR = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          readEn, readRdy, readDataEn;
    logic [AW-1:0] readAddr;
    logic [DW-1:0] readData;
    logic          c0TxValid, c0TxAlmFull, c0RxValid, errUnexpectedRsp;
    logic [AW-1:0] c0TxAddr;
    logic [15:0]   c0TxMdata, c0RxMdata, statNumReads;
    logic [DW-1:0] c0RxData;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cci_mpf_vtp_pt_fim_reader dut (
        .clk(clk), .reset_n(reset_n),
        .readEn(readEn), .readAddr(readAddr), .readRdy(readRdy),
        .readDataEn(readDataEn), .readData(readData),
        .c0TxValid(c0TxValid), .c0TxAddr(c0TxAddr), .c0TxMdata(c0TxMdata),
        .c0TxAlmFull(c0TxAlmFull),
        .c0RxValid(c0RxValid), .c0RxMdata(c0RxMdata), .c0RxData(c0RxData),
        .errUnexpectedRsp(errUnexpectedRsp), .statNumReads(statNumReads)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[AW-1:0];
    endfunction

    function automatic logic [15:0] exp_stat(input int n);
`ifdef CCI_MPF_VTP_PT_FIM_READER_STATS_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return (n < 0) ? 16'd1 : 16'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        readEn = 0; readAddr = '0; c0TxAlmFull = 0;
        c0RxValid = 0; c0RxMdata = '0; c0RxData = '0;
        reset_n = 0;
        #1;
        chk("rst_rdy", readRdy, 1);
        chk("rst_txv", c0TxValid, 0);
        chk("rst_den", readDataEn, 0);
        chk("rst_data", readData, 0);
        chk("rst_err", errUnexpectedRsp, 0);
        chk("rst_stat", statNumReads, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        tick();
    endtask

    task automatic send_rsp(input logic [15:0] md, input logic [DW-1:0] d);
        c0RxValid = 1; c0RxMdata = md; c0RxData = d;
        tick();
        c0RxValid = 0;
    endtask

    logic [AW-1:0] ooo_a [4];
    logic [DW-1:0] ooo_d [4];
    logic [DW-1:0] d0;

    // random-phase model state
    logic [AW-1:0] req_addr [$];
    logic [DW-1:0] req_data [$];
    int            resp_cyc [$];
    int            ost_seq [$];
    int            ost_rdy [$];
    int            n_acc, n_del, seq_tx;
    logic          pend, exp_rdy;
    logic [7:0]    mk;

    initial begin
        // single read, latency and hold
        do_reset();
        readEn = 1; readAddr = 42'h123;
        tick();
        readEn = 0;
        chk("one_txv", c0TxValid, 1);
        chk("one_addr", c0TxAddr, 42'h123);
        chk("one_md", c0TxMdata, 16'hA500);
        tick();
        chk("one_txpulse", c0TxValid, 0);
        d0 = rand_data();
        send_rsp(16'hA500, d0);
        chk("one_r1", readDataEn, 0);
        tick();
        chk("one_r2_en", readDataEn, 1);
        chk("one_r2_data", readData, d0);
        tick();
        chk("one_pulse", readDataEn, 0);
        chk("one_hold", readData, d0);

        // out-of-order completion with a full ROB
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ooo_a[i] = rand_addr();
            ooo_d[i] = rand_data();
            readEn = 1; readAddr = ooo_a[i];
            tick();
            chk("ooo_txv", c0TxValid, 1);
            chk("ooo_addr", c0TxAddr, ooo_a[i]);
            chk("ooo_md", c0TxMdata, {8'hA5, 8'(i)});
        end
        chk("full_rdy", readRdy, 0);
        readAddr = rand_addr();
        tick();
        readEn = 0;
        chk("full_ignored", c0TxValid, 0);
        send_rsp(16'hA503, ooo_d[3]);
        send_rsp(16'hA501, ooo_d[1]);
        for (int i = 0; i < 4; i++) begin
            chk("ooo_wait", readDataEn, 0);
            tick();
        end
        chk("ooo_rdy_hold", readRdy, 0);
        send_rsp(16'hA500, ooo_d[0]);
        chk("ooo_r1", readDataEn, 0);
        chk("rel_rdy0", readRdy, 0);
        tick();
        chk("ooo_d0_en", readDataEn, 1);
        chk("ooo_d0", readData, ooo_d[0]);
        chk("rel_rdy1", readRdy, 1);
        tick();
        chk("ooo_d1_en", readDataEn, 1);
        chk("ooo_d1", readData, ooo_d[1]);
        tick();
        chk("ooo_gap", readDataEn, 0);
        send_rsp(16'hA502, ooo_d[2]);
        chk("ooo_r1b", readDataEn, 0);
        tick();
        chk("ooo_d2_en", readDataEn, 1);
        chk("ooo_d2", readData, ooo_d[2]);
        tick();
        chk("ooo_d3_en", readDataEn, 1);
        chk("ooo_d3", readData, ooo_d[3]);
        tick();
        chk("ooo_end", readDataEn, 0);
        chk("ooo_stat", statNumReads, exp_stat(4));

        // almost-full backpressure on an empty ROB
        c0TxAlmFull = 1;
        #1;
        chk("alm_rdy0", readRdy, 0);
        tick();
        c0TxAlmFull = 0;
        tick();
        chk("alm_rdy1", readRdy, 1);

        // foreign and unexpected responses
        send_rsp(16'h1200, rand_data());
        chk("foreign_err", errUnexpectedRsp, 0);
        tick();
        chk("foreign_den", readDataEn, 0);
        chk("foreign_rdy", readRdy, 1);
        send_rsp(16'hA502, rand_data());
        chk("unexp_err", errUnexpectedRsp, 1);
        repeat (3) tick();
        chk("unexp_sticky", errUnexpectedRsp, 1);

        // reset with two reads in flight
        readEn = 1; readAddr = rand_addr();
        tick();
        readAddr = rand_addr();
        tick();
        readEn = 0;
        reset_n = 0;
        #1;
        chk("mid_txv", c0TxValid, 0);
        chk("mid_den", readDataEn, 0);
        chk("mid_data", readData, 0);
        chk("mid_err", errUnexpectedRsp, 0);
        chk("mid_stat", statNumReads, 0);
        @(negedge clk);
        reset_n = 1;
        tick();
        send_rsp(16'hA500, rand_data());
        chk("late_err", errUnexpectedRsp, 1);
        readEn = 1; readAddr = 42'h3AB;
        tick();
        readEn = 0;
        chk("post_md", c0TxMdata, 16'hA500);
        chk("post_addr", c0TxAddr, 42'h3AB);
        d0 = rand_data();
        send_rsp(16'hA500, d0);
        tick();
        chk("post_en", readDataEn, 1);
        chk("post_data", readData, d0);

        // randomized traffic against the in-order model
        do_reset();
        n_acc = 0; n_del = 0; seq_tx = 0; pend = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            c0TxAlmFull = ($urandom_range(0, 7) == 0);
            readEn      = (c < 2600) && ($urandom_range(0, 1) == 1);
            readAddr    = rand_addr();
            c0RxValid   = 0;
            c0RxMdata   = 16'($urandom);
            c0RxData    = rand_data();
            if (ost_seq.size() > 0 && $urandom_range(0, 2) != 0) begin
                int k, s;
                k = $urandom_range(0, ost_seq.size() - 1);
                if (ost_rdy[k] <= c) begin
                    s = ost_seq[k];
                    c0RxValid = 1;
                    c0RxMdata = {8'hA5, 8'(s % MAXR)};
                    c0RxData  = req_data[s];
                    resp_cyc[s] = c;
                    ost_seq.delete(k);
                    ost_rdy.delete(k);
                end
            end else if ($urandom_range(0, 9) == 0) begin
                mk = 8'($urandom_range(0, 255));
                if (mk == 8'hA5) mk = 8'h5A;
                c0RxValid = 1;
                c0RxMdata = {mk, 8'($urandom)};
            end
            @(negedge clk);
            if (readDataEn) begin
                if (n_del < n_acc) begin
                    chk("rnd_data", readData, req_data[n_del]);
                    chk("rnd_lat", (resp_cyc[n_del] >= 0) && (c >= resp_cyc[n_del] + 2), 1);
                    n_del++;
                end else begin
                    chk("rnd_spurious", readDataEn, 0);
                end
            end
            chk("rnd_txv", c0TxValid, pend);
            if (pend && c0TxValid) begin
                chk("rnd_addr", c0TxAddr, req_addr[seq_tx]);
                chk("rnd_md", c0TxMdata, {8'hA5, 8'(seq_tx % MAXR)});
                ost_seq.push_back(seq_tx);
                ost_rdy.push_back(c + $urandom_range(1, 5));
            end
            exp_rdy = !c0TxAlmFull && ((n_acc - n_del) < MAXR);
            chk("rnd_rdy", readRdy, exp_rdy);
            pend = readEn && exp_rdy;
            if (pend) begin
                seq_tx = n_acc;
                req_addr.push_back(readAddr);
                req_data.push_back(rand_data());
                resp_cyc.push_back(-1);
                n_acc++;
            end
        end
        readEn = 0; c0RxValid = 0;
        chk("rnd_drained", n_del, n_acc);
        chk("rnd_enough", n_acc > 10, 1);
        chk("rnd_err", errUnexpectedRsp, 0);
        chk("rnd_stat", statNumReads, exp_stat(n_del));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
